bpsk_frame_sync: RTL and testbench

Bit-timing recovery, frame synchronizer and byte packer, directly downstream of `bpsk_demodulator_top`. It consumes the demodulator's hard-decision bit stream `data_out`, one sample per clock. It recovers the bit centre from transitions, hunts for a sync word in either polarity to resolve the BPSK 180° phase ambiguity, and emits a fixed-length payload as bytes with one-cycle valid strobes for the packet/host interface.

---
 rtl/bpsk_frame_sync.sv | 189 ++++++++++++++++++
 tb/tb_bpsk_frame_sync.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_frame_sync.sv
// rtl/bpsk_frame_sync.sv - BPSK bit-timing recovery, sync word hunt and payload byte packer
module bpsk_frame_sync #(
  parameter int                  SAMPLES_PER_BIT = 8,
  parameter int                  SYNC_LEN        = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD       = 16'hF628,
  parameter int                  PAYLOAD_BYTES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       locked,
  output logic       inverted
);

  localparam int CNT_W  = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int FILL_W = $clog2(SYNC_LEN + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SAMPLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(SAMPLES_PER_BIT / 2);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_LEN);
  localparam logic [7:0]        LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  // Registered state
  state_t              state_q,       state_d;
  logic                r_in_q,        r_in_d;
  logic                r_prev_q,      r_prev_d;
  logic [CNT_W-1:0]    cnt_q,         cnt_d;
  logic [SYNC_LEN-1:0] sr_q,          sr_d;
  logic [FILL_W-1:0]   fill_q,        fill_d;
  logic [2:0]          bit_cnt_q,     bit_cnt_d;
  logic [7:0]          byte_cnt_q,    byte_cnt_d;
  logic [6:0]          byte_sr_q,     byte_sr_d;
  logic [7:0]          data_out_q,    data_out_d;
  logic                data_valid_q,  data_valid_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_done_q,  frame_done_d;
  logic                locked_q,      locked_d;
  logic                inverted_q,    inverted_d;

  // Combinational helpers
  logic                bit_edge;
  logic                stb;
  logic [SYNC_LEN-1:0] sr_next;
  logic [FILL_W-1:0]   fill_next;
  logic                bit_val;

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign locked      = locked_q;
  assign inverted    = inverted_q;

  // Timing recovery, sync hunt and byte packing next-state logic
  always_comb begin
    state_d       = state_q;
    r_in_d        = bit_in;
    r_prev_d      = r_in_q;
    cnt_d         = cnt_q;
    sr_d          = sr_q;
    fill_d        = fill_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    byte_sr_d     = byte_sr_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    locked_d      = locked_q;
    inverted_d    = inverted_q;

    // A transition re-centres the phase counter; otherwise it free-runs one bit period
    bit_edge = r_in_q ^ r_prev_q;
    if (bit_edge) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Mid-bit sample point; a late edge landing on it suppresses the sample
    stb       = (cnt_q == CNT_MID) && !bit_edge;
    sr_next   = {sr_q[SYNC_LEN-2:0], r_in_q};
    fill_next = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    bit_val   = r_in_q ^ inverted_q;

    // locked stays up through the frame_done cycle and drops one cycle later
    if (frame_done_q) begin
      locked_d = 1'b0;
    end

    case (state_q)
      ST_HUNT: begin
        if (stb) begin
          sr_d   = sr_next;
          fill_d = fill_next;
          if (fill_next == FILL_FULL) begin
            if (sr_next == SYNC_WORD) begin
              state_d       = ST_PAYLOAD;
              inverted_d    = 1'b0;
              frame_start_d = 1'b1;
              locked_d      = 1'b1;
            end else if (sr_next == ~SYNC_WORD) begin
              state_d       = ST_PAYLOAD;
              inverted_d    = 1'b1;
              frame_start_d = 1'b1;
              locked_d      = 1'b1;
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (stb) begin
          if (bit_cnt_q == 3'd7) begin
            data_out_d   = {byte_sr_q, bit_val};
            data_valid_d = 1'b1;
            bit_cnt_d    = 3'd0;
            if (byte_cnt_q == LAST_BYTE) begin
              // Frame complete: the next hunt needs a full set of fresh bits
              frame_done_d = 1'b1;
              state_d      = ST_HUNT;
              sr_d         = '0;
              fill_d       = '0;
              byte_cnt_d   = 8'd0;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end else begin
            byte_sr_d = {byte_sr_q[5:0], bit_val};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_HUNT;
      r_in_q        <= 1'b0;
      r_prev_q      <= 1'b0;
      cnt_q         <= '0;
      sr_q          <= '0;
      fill_q        <= '0;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= 8'd0;
      byte_sr_q     <= 7'd0;
      data_out_q    <= 8'd0;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      locked_q      <= 1'b0;
      inverted_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_in_q        <= r_in_d;
      r_prev_q      <= r_prev_d;
      cnt_q         <= cnt_d;
      sr_q          <= sr_d;
      fill_q        <= fill_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      byte_sr_q     <= byte_sr_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      locked_q      <= locked_d;
      inverted_q    <= inverted_d;
    end
  end

endmodule

// File: tb/tb_bpsk_frame_sync.sv
// tb/tb_bpsk_frame_sync.sv - self-checking bench for bpsk_frame_sync
module tb_bpsk_frame_sync;

  localparam int          SPB  = 8;
  localparam logic [15:0] SYNC = 16'hF628;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_in = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_start;
  logic       frame_done;
  logic       locked;
  logic       inverted;

  bpsk_frame_sync #(
    .SAMPLES_PER_BIT(SPB),
    .SYNC_LEN       (16),
    .SYNC_WORD      (SYNC),
    .PAYLOAD_BYTES  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .locked     (locked),
    .inverted   (inverted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } exp_t;
  exp_t sb[$];

  int   n_dv = 0, n_fs = 0, n_fd = 0, fs_cyc = -1, lock_seen = 0;
  logic fd_prev = 1'b0;

  bit inv_mode = 1'b0;
  bit jit_mode = 1'b0;
  int dur_toggle = 0;
  int last_sync_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      if (data_valid) begin
        n_dv++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL dv_unexpected: got byte %0h, expected no byte", data_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("byte", {24'd0, data_out}, {24'd0, e.b});
          check("frame_done_on_last", {31'd0, frame_done}, {31'd0, e.last});
        end
      end else if (frame_done) begin
        check("frame_done_needs_dv", {31'd0, data_valid}, 32'd1);
      end
      if (frame_start) begin
        n_fs++;
        fs_cyc = cyc;
      end
      if (frame_done) begin
        n_fd++;
        check("locked_at_done", {31'd0, locked}, 32'd1);
      end
      if (locked) lock_seen++;
      if (fd_prev) check("locked_drop", {31'd0, locked}, 32'd0);
      fd_prev = frame_done;
    end else begin
      fd_prev = 1'b0;
    end
  end

  task automatic send_bit(input logic b);
    int d;
    if (jit_mode) begin
      d = (dur_toggle != 0) ? 9 : 7;
      dur_toggle = 1 - dur_toggle;
    end else begin
      d = SPB;
    end
    bit_in = b ^ inv_mode;
    repeat (d) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 20; i++) send_bit((i % 2) == 0);
  endtask

  task automatic send_sync();
    for (int i = 15; i >= 1; i--) send_bit(SYNC[i]);
    last_sync_start = cyc;
    send_bit(SYNC[0]);
  endtask

  task automatic send_payload(input logic [31:0] p);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] bv;
      bv = p[31 - 8 * k -: 8];
      sb.push_back('{b: bv, last: (k == 3)});
      send_bits({24'd0, bv}, 8);
    end
  endtask

  task automatic send_trailer();
    for (int i = 0; i < 4; i++) send_bit((i % 2) == 1);
  endtask

  task automatic clear_counts();
    n_dv = 0; n_fs = 0; n_fd = 0; fs_cyc = -1; lock_seen = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bit_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    clear_counts();
    dur_toggle = 0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        inv;
    logic        jit;
    logic [31:0] pay;
  } vec_t;
  vec_t vecs[5];

  initial begin
    vecs[0] = '{inv: 1'b0, jit: 1'b0, pay: 32'h12345678};
    vecs[1] = '{inv: 1'b1, jit: 1'b0, pay: 32'h12345678};
    vecs[2] = '{inv: 1'b0, jit: 1'b1, pay: 32'h12345678};
    vecs[3] = '{inv: 1'b1, jit: 1'b1, pay: 32'h00FF5AA5};
    vecs[4] = '{inv: 1'b0, jit: 1'b0, pay: 32'hFF00C33C};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_out",    {24'd0, data_out}, 32'd0);
    check("rst_data_valid",  {31'd0, data_valid}, 32'd0);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_frame_done",  {31'd0, frame_done}, 32'd0);
    check("rst_locked",      {31'd0, locked}, 32'd0);
    check("rst_inverted",    {31'd0, inverted}, 32'd0);

    // Table-driven single frames
    for (int v = 0; v < 5; v++) begin
      do_reset();
      inv_mode = vecs[v].inv;
      jit_mode = vecs[v].jit;
      send_preamble();
      send_sync();
      send_payload(vecs[v].pay);
      send_trailer();
      check("vec_dv_count", n_dv, 4);
      check("vec_fs_count", n_fs, 1);
      check("vec_fd_count", n_fd, 1);
      check("vec_sb_empty", sb.size(), 0);
      check("vec_inverted", {31'd0, inverted}, {31'd0, vecs[v].inv});
      check("vec_data_hold", {24'd0, data_out}, {24'd0, vecs[v].pay[7:0]});
      check("vec_locked_after", {31'd0, locked}, 32'd0);
      if (!vecs[v].jit) check("vec_fs_timing", fs_cyc, last_sync_start + 7);
    end
    inv_mode = 1'b0;
    jit_mode = 1'b0;

    // False sync: 15 bits of the sync tail after reset, then a breaking pattern
    do_reset();
    send_bits({17'd0, SYNC[14:0]}, 15);
    for (int i = 0; i < 8; i++) send_bit((i % 2) == 0);
    check("false_sync_fs", n_fs, 0);
    check("false_sync_locked", lock_seen, 0);

    // Reset in the middle of the payload
    do_reset();
    send_preamble();
    send_sync();
    sb.push_back('{b: 8'h12, last: 1'b0});
    send_bits(32'h12, 8);
    sb.push_back('{b: 8'h34, last: 1'b0});
    send_bits(32'h34, 8);
    send_bits(32'h2, 3);
    check("mid_dv_before_rst", n_dv, 2);
    check("mid_locked_before_rst", {31'd0, locked}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_data_out", {24'd0, data_out}, 32'd0);
    check("mid_rst_locked",   {31'd0, locked}, 32'd0);
    check("mid_rst_valid",    {31'd0, data_valid}, 32'd0);
    check("mid_rst_done",     {31'd0, frame_done}, 32'd0);
    check("mid_rst_start",    {31'd0, frame_start}, 32'd0);
    check("mid_rst_inverted", {31'd0, inverted}, 32'd0);
    check("mid_no_fd", n_fd, 0);
    check("mid_sb_empty", sb.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    clear_counts();
    @(posedge clk);
    #1;
    send_preamble();
    send_sync();
    send_payload(32'h9ABCDEF0);
    send_trailer();
    check("post_rst_dv", n_dv, 4);
    check("post_rst_fd", n_fd, 1);
    check("post_rst_sb", sb.size(), 0);

    // Back-to-back frames with zero gap
    do_reset();
    send_preamble();
    send_sync();
    send_payload(32'h01020304);
    send_sync();
    send_payload(32'hA1A2A3A4);
    send_trailer();
    check("b2b_dv", n_dv, 8);
    check("b2b_fs", n_fs, 2);
    check("b2b_fd", n_fd, 2);
    check("b2b_sb", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
